// File: rtl/tia_hsync_pkg.sv
// TIA horizontal timing: shared constants and the LFSR step function.
// Decode values are states of the 57-count horizontal LFSR.
package tia_hsync_pkg;

  localparam int PHASES    = 4;
  localparam int HS_PERIOD = 57;

  localparam logic [5:0] HS_SHS  = 6'b111100;
  localparam logic [5:0] HS_RHS  = 6'b110111;
  localparam logic [5:0] HS_RCB  = 6'b001111;
  localparam logic [5:0] HS_RHB  = 6'b011100;
  localparam logic [5:0] HS_LRHB = 6'b010111;
  localparam logic [5:0] HS_CNT  = 6'b101100;
  localparam logic [5:0] HS_SHB  = 6'b010100;

  // Shift right with XNOR feedback into the insert bit.
  function automatic logic [5:0] hs_step(input logic [5:0] s);
    return {~(s[1] ^ s[0]), s[5:1]};
  endfunction

endpackage

// File: rtl/tia_hlfsr_decode.sv
// Horizontal event decodes: pure compares on the LFSR state.
// Each strobe is high for exactly one count of the line.
module tia_hlfsr_decode
  import tia_hsync_pkg::*;
(
  input  logic [5:0] out,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       cnt,
  output logic       shb
);

  assign shs  = (out == HS_SHS);
  assign rhs  = (out == HS_RHS);
  assign rcb  = (out == HS_RCB);
  assign rhb  = (out == HS_RHB);
  assign lrhb = (out == HS_LRHB);
  assign cnt  = (out == HS_CNT);
  assign shb  = (out == HS_SHB);

endmodule

// File: rtl/tia_hsync_counter.sv
// TIA horizontal sync counter: 4-phase enable generator plus
// a 57-state LFSR stepped on hphi2, with line-event decodes.
module tia_hsync_counter
  import tia_hsync_pkg::*;
(
  input  logic       clk,
  input  logic       r,
  output logic       hphi1,
  output logic       hphi2,
  output logic [5:0] out,
  output logic       shb,
  output logic       rsynd,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       cnt
);

  logic [1:0] p_q;
  logic [5:0] lfsr_q, lfsr_d;
  logic       rsynd_q, rsynd_d;

  // Reset gates the enables so nothing steps while r is held.
  assign hphi1 = (p_q == 2'd0) & ~r;
  assign hphi2 = (p_q == 2'd2) & ~r;

  assign out   = lfsr_q;
  assign rsynd = rsynd_q;

  always_comb begin
    lfsr_d  = lfsr_q;
    rsynd_d = rsynd_q;
    if (hphi2) begin
      if (shb) begin
        lfsr_d  = 6'b000000;
        rsynd_d = 1'b1;
      end else begin
        lfsr_d  = hs_step(lfsr_q);
        rsynd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      p_q     <= 2'd0;
      lfsr_q  <= 6'b000000;
      rsynd_q <= 1'b1;
    end else begin
      p_q     <= p_q + 2'd1;
      lfsr_q  <= lfsr_d;
      rsynd_q <= rsynd_d;
    end
  end

  tia_hlfsr_decode u_dec (
    .out  (lfsr_q),
    .shs  (shs),
    .rhs  (rhs),
    .rcb  (rcb),
    .rhb  (rhb),
    .lrhb (lrhb),
    .cnt  (cnt),
    .shb  (shb)
  );

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Directed bench for tia_hsync_counter against a hand-derived
// table of all 57 LFSR states and the decode positions.
module tb_tia_hsync_counter;

  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic       hphi1, hphi2, shb, rsynd;
  logic       shs, rhs, rcb, rhb, lrhb, cnt;
  logic [5:0] out;
  logic [6:0] dec;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int ph    = 0;
  int n     = 0;

  localparam logic [5:0] TBL [57] = '{
    6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b111100,
    6'b111110, 6'b011111, 6'b101111, 6'b110111, 6'b111011,
    6'b111101, 6'b011110, 6'b001111, 6'b100111, 6'b110011,
    6'b111001, 6'b011100, 6'b101110, 6'b010111, 6'b101011,
    6'b110101, 6'b011010, 6'b001101, 6'b000110, 6'b000011,
    6'b100001, 6'b010000, 6'b101000, 6'b110100, 6'b111010,
    6'b011101, 6'b001110, 6'b000111, 6'b100011, 6'b110001,
    6'b011000, 6'b101100, 6'b110110, 6'b011011, 6'b101101,
    6'b010110, 6'b001011, 6'b100101, 6'b010010, 6'b001001,
    6'b000100, 6'b100010, 6'b010001, 6'b001000, 6'b100100,
    6'b110010, 6'b011001, 6'b001100, 6'b100110, 6'b010011,
    6'b101001, 6'b010100
  };

  always #5 clk = ~clk;

  assign dec = {shs, rhs, rcb, rhb, lrhb, cnt, shb};

  tia_hsync_counter dut (
    .clk   (clk),
    .r     (r),
    .hphi1 (hphi1),
    .hphi2 (hphi2),
    .out   (out),
    .shb   (shb),
    .rsynd (rsynd),
    .shs   (shs),
    .rhs   (rhs),
    .rcb   (rcb),
    .rhb   (rhb),
    .lrhb  (lrhb),
    .cnt   (cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d ph=%0d got=%h exp=%h",
               tag, k, ph, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_dec(input int c);
    case (c)
      4:       return 7'b1000000;
      8:       return 7'b0100000;
      12:      return 7'b0010000;
      16:      return 7'b0001000;
      18:      return 7'b0000100;
      36:      return 7'b0000010;
      56:      return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic do_reset(input int ncyc);
    r = 1'b1;
    #1;
    chk("rst_ph", {hphi1, hphi2}, 2'b00);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      chk("rst_ph", {hphi1, hphi2}, 2'b00);
      chk("rst_st", {rsynd, out, dec}, {1'b1, 6'b0, 7'b0});
    end
    r  = 1'b0;
    k  = 0;
    ph = 0;
    #1;
  endtask

  task automatic cyc();
    int c;
    c = k % 57;
    chk("ph", {hphi1, hphi2}, {ph == 0, ph == 2});
    chk("st", {rsynd, out, dec}, {c == 0, TBL[c], exp_dec(c)});
    if (ph == 2) k++;
    ph = (ph + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int kt, input int pt, output int ncyc);
    ncyc = 0;
    while (!(k == kt && ph == pt) && ncyc < 2000) begin
      cyc();
      ncyc++;
    end
    chk("run_to", {31'b0, k == kt && ph == pt}, 1);
  endtask

  initial begin
    do_reset(3);
    run_to(57, 0, n);
    chk("line_clks", n, 228);
    chk("wrap_st", {rsynd, out, hphi1}, {1'b1, 6'b0, 1'b1});
    run_to(115, 0, n);

    do_reset(2);
    run_to(30, 1, n);
    do_reset(2);
    run_to(4, 0, n);
    chk("shs_after_rst", {hphi1, dec}, {1'b1, 7'b1000000});
    run_to(20, 0, n);

    run_to(56, 2, n);
    chk("shb_phi2", {hphi2, shb, out}, {2'b11, 6'b010100});
    do_reset(1);
    chk("post_rst_phi1", {hphi1, out}, {1'b1, 6'b0});
    run_to(57, 0, n);
    chk("line_clks2", n, 228);
    run_to(58, 1, n);
    chk("rsynd58", {rsynd, out}, {1'b0, 6'b100000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tia_hsync_counter.md
Name: tia_hsync_counter

Overview:
- Horizontal timing generator for the TIA.
- Derives two non-overlapping phase enables (hphi1/hphi2) from the colour clock, one pair per 4 clocks.
- Clocks a 6-bit, 57-state horizontal LFSR with those enables and decodes fixed LFSR states into one-count horizontal event strobes.
- One line = 57 counts = 228 clocks.
- Feeds HSYNC/HBLANK/colour-burst logic.

Parameters:
- none. Period and decode values are fixed constants.

Ports:
- clk    in   1  colour clock; all state updates on its rising edge
- r      in   1  synchronous active-high reset
- hphi1  out  1  phase-1 enable, high 1 clk of every 4
- hphi2  out  1  phase-2 enable, high 1 clk of every 4, two clks after hphi1
- out    out  6  LFSR state; out[5] is the insert (left) bit
- shb    out  1  decode of 010100 (count 56): end of line, forces reload to 0
- rsynd  out  1  high while the current LFSR state was produced by a zero reload (shb wrap or reset)
- shs    out  1  decode 111100, count 4: set HSYNC
- rhs    out  1  decode 110111, count 8: reset HSYNC
- rcb    out  1  decode 001111, count 12: reset colour burst
- rhb    out  1  decode 011100, count 16: reset HBLANK
- lrhb   out  1  decode 010111, count 18: late reset HBLANK
- cnt    out  1  decode 101100, count 36: centre

Behaviour:
- Phase counter p, 2 bits, increments every clk and wraps 3 to 0.
  - hphi1 = (p==0) and not r.
  - hphi2 = (p==2) and not r.
- Reset: at a clk edge with r=1, set p<=0, out<=000000, rsynd<=1. While r is high, hphi1=hphi2=0.
- First clk after r falls: p=0 and hphi1=1.
- LFSR update happens only on the clk edge where hphi2=1:
  - If shb=1: out<=000000 and rsynd<=1.
  - Else: out<={~(out[1]^out[0]), out[5:1]} (shift right, XNOR feedback into bit 5) and rsynd<=0.
- Consequence: during the k-th hphi1 pulse after reset (k=0 first), out = state (k mod 57).
- Required sequence, counts 0..8: 000000, 100000, 110000, 111000, 111100, 111110, 011111, 101111, 110111.
- Required anchors: count 12 = 001111; 16 = 011100; 18 = 010111; 36 = 101100; 56 = 010100; count 57 = 000000 again.
- Decode outputs are purely combinational equality compares on out, with no extra latency.
- Exactly one decode is high per count at the listed counts; at all other counts every decode is 0.
- shb is high only at count 56.
- Reset mid-line: the line restarts at count 0 on the first hphi1 after r falls, and no decode glitches during reset.
- The 7 unused states of the 64 are unreachable. If reached (e.g. by SEU), the design is not required to self-correct, except that r always recovers it.

Decomposition:
- Shared package tia_hsync_pkg holds:
  - 6-bit localparams HS_SHS, HS_RHS, HS_RCB, HS_RHB, HS_LRHB, HS_CNT, HS_SHB with the values above.
  - HS_PERIOD = 57 and PHASES = 4.
- One natural combinational sub-module, tia_hlfsr_decode: input out[5:0], outputs shs, rhs, rcb, rhb, lrhb, cnt, shb.
- The phase counter and the LFSR stay in the top module.

Test Plan:
- Reset 3 clks, release, count hphi1 pulses k. At k=4 only shs=1; k=8 only rhs; k=12 only rcb; k=16 only rhb; k=18 only lrhb; k=36 only cnt; all other k in 0..56 all decodes 0. Repeat the same checks for k+57, stopping at k=114.
- Phase check: hphi1 and hphi2 each period 4 clks, never high together, hphi2 exactly 2 clks after hphi1. 228 clks per line.
- Sequence check: out at k=0..8 matches the listed values. Count 56 = 010100 with shb=1. k=57 gives out=000000 with rsynd=1, and rsynd=0 at k=58.
- Reset mid-line at k=30 (any p): while r is high, hphi1=hphi2=0 and out=000000. After release, k restarts at 0 and shs fires 4 hphi1 pulses later.
- Reset asserted on the exact clk where hphi2=1 and shb=1: out=000000, p=0. The next line timing is identical to a fresh reset.
